fwd_ctrl: RTL

Operand-forwarding and hazard controller for the 5-stage 16-bit core (IF/ID/EX/MEM/WB).
- Sits directly upstream of the two 4:1 operand muxes at the ALU inputs and drives their S1/S0 select pairs.
- Tracks destination registers of in-flight instructions and computes the selects in ID.
- Registers the selects into EX together with the instruction.
- Detects load-use hazards, requests a one-cycle stall, and keeps a saturating stall counter for performance monitoring.

---
 rtl/fwd_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage core.
// Computes ALU operand-mux selects in ID and registers them into EX alongside the instruction.
module fwd_ctrl #(
    parameter int RA_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_a_pc,
    input  logic             id_b_imm,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_rd_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic             ex_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EXM  = 2'b01;
    localparam logic [1:0] SEL_MWB  = 2'b10;
    localparam logic [1:0] SEL_ALT  = 2'b11;

    // MEM/WB producers are bypassed inside the register file, so only DX and XM are tracked here.
    logic            dx_valid;
    logic            dx_we;
    logic            dx_load;
    logic [RA_W-1:0] dx_rd;
    logic            xm_valid;
    logic            xm_we;
    logic [RA_W-1:0] xm_rd;

    logic       dx_match_a;
    logic       dx_match_b;
    logic       xm_match_a;
    logic       xm_match_b;
    logic       hazard;
    logic       issue;
    logic [1:0] sel_a_next;
    logic [1:0] sel_b_next;

    function automatic logic producer_match(
        input logic            valid,
        input logic            we,
        input logic [RA_W-1:0] rd,
        input logic [RA_W-1:0] src,
        input logic            used
    );
        return valid && we && (rd == src) && (src != '0) && used;
    endfunction

    always_comb begin
        dx_match_a = producer_match(dx_valid, dx_we, dx_rd, id_rs1, id_rs1_used);
        dx_match_b = producer_match(dx_valid, dx_we, dx_rd, id_rs2, id_rs2_used);
        xm_match_a = producer_match(xm_valid, xm_we, xm_rd, id_rs1, id_rs1_used);
        xm_match_b = producer_match(xm_valid, xm_we, xm_rd, id_rs2, id_rs2_used);

        // A PC or immediate operand never reads the register, so it cannot cause a load-use stall.
        hazard = dx_load && ((dx_match_a && !id_a_pc) || (dx_match_b && !id_b_imm));
        stall  = id_valid && !flush && hazard;
        issue  = id_valid && !flush && !hazard;

        sel_a_next = SEL_RF;
        if (id_a_pc)         sel_a_next = SEL_ALT;
        else if (dx_match_a) sel_a_next = SEL_EXM;
        else if (xm_match_a) sel_a_next = SEL_MWB;

        sel_b_next = SEL_RF;
        if (id_b_imm)        sel_b_next = SEL_ALT;
        else if (dx_match_b) sel_b_next = SEL_EXM;
        else if (xm_match_b) sel_b_next = SEL_MWB;
    end

    // Pipeline tracking: a bubble carries valid=0 and neutral selects into EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_valid  <= 1'b0;
            dx_we     <= 1'b0;
            dx_load   <= 1'b0;
            dx_rd     <= '0;
            xm_valid  <= 1'b0;
            xm_we     <= 1'b0;
            xm_rd     <= '0;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
        end else begin
            xm_valid <= dx_valid;
            xm_we    <= dx_we;
            xm_rd    <= dx_rd;
            if (issue) begin
                dx_valid  <= 1'b1;
                dx_we     <= id_rd_we;
                dx_load   <= id_is_load;
                dx_rd     <= id_rd;
                fwd_a_sel <= sel_a_next;
                fwd_b_sel <= sel_b_next;
            end else begin
                dx_valid  <= 1'b0;
                dx_we     <= 1'b0;
                dx_load   <= 1'b0;
                dx_rd     <= '0;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end
        end
    end

    // Saturating performance counter of stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign ex_valid = dx_valid;

endmodule
